inst_loader: RTL and testbench
==============================

# inst_loader

Program loader that writes the instruction memory. It accepts a byte stream over a valid/ready handshake, parses a 4-byte length header, assembles little-endian 32-bit instruction words, and issues one write per word to the instruction memory write port, starting at word address `BASE_ADDR`. It sits between a host byte source (UART/debug bridge) and the instruction store. The CPU fetches from that store by word-indexed PC.

## Interface
Parameters:
- `ADDR_WIDTH`, 20: word-address width of the instruction memory (2^20 words).
- `BASE_ADDR`, 0: first word address written.

Ports:
- `clk`  in  1  — single clock, rising edge.
- `reset`  in  1  — asynchronous, active-high.
- `start`  in  1  — one-cycle request to begin a load; honoured only in IDLE.
- `in_valid`  in  1  — byte available.
- `in_data`  in  8  — stream byte.
- `in_ready`  out  1  — loader accepts a byte this cycle.
- `mem_we`  out  1  — instruction memory write strobe, one cycle per word.
- `mem_addr`  out  ADDR_WIDTH  — word address for the write.
- `mem_wdata`  out  32  — instruction word.
- `busy`  out  1  — load in progress.
- `done`  out  1  — one-cycle pulse at the end of a load.
- `error`  out  1  — sticky until the next accepted `start`.
- `word_count`  out  ADDR_WIDTH+1  — words written in the current or last load.

## Operation
- A byte transfers when `in_valid && in_ready`. The byte order is little-endian: the first byte of a group goes to bits 7:0.
- States:
  - IDLE: `in_ready`=0. `start` → HDR. Clears `error` and `word_count`, and loads the address counter with `BASE_ADDR`.
  - HDR: `in_ready`=1. Collects 4 bytes into length N (32 bits). On the 4th byte:
    - N > 2^ADDR_WIDTH − BASE_ADDR → set `error`, go to FIN. No writes occur.
    - N = 0 → go to FIN (or CSUM when configured).
    - Otherwise go to DATA.
  - DATA: `in_ready`=1. Collects 4 bytes per word. On the 4th byte:
    - The word and address are registered.
    - `mem_we` pulses on the next cycle.
    - The address counter and `word_count` increment.
    - After word N, go to FIN (or CSUM).
  - CSUM (only with the macro): `in_ready`=1. Collects a 4-byte checksum, then goes to FIN.
  - FIN: `done`=1 for one cycle, then IDLE.
- `start` is ignored outside IDLE.
- The address counter is ADDR_WIDTH bits. Wrap-around cannot occur because the length check rejects any N that would wrap.
- Reset mid-load returns to IDLE immediately. Words already written stay in memory, and the partial byte group is discarded.

## Timing
- Reset values: `in_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0, `done`=0, `error`=0, `word_count`=0.
- `busy`=1 in HDR, DATA, CSUM, and FIN.
- Write latency: when the 4th byte of a word is accepted at cycle t, `mem_we`=1 at t+1 with stable `mem_addr` and `mem_wdata`. `mem_addr` and `mem_wdata` hold until the next write.
- End of load, last data byte accepted at t:
  - Without checksum: `mem_we` at t+1, `done` at t+2, `busy`=0 at t+3.
  - With checksum: when the last checksum byte is accepted at t, `done` and the final `error` are valid at t+1.
- Gaps in `in_valid` stall the loader without losing state. The loader never deasserts `in_ready` mid-group.
- A `start` in the same cycle as `reset` is lost.

## Configuration
- `INST_LOADER_CHECKSUM_EN` defined:
  - After the data words, the loader expects 4 further bytes: the sum of all N words mod 2^32 (0 when N=0).
  - A mismatch sets `error` at the `done` pulse. Words are still written.
- `INST_LOADER_CHECKSUM_EN` undefined: no CSUM state, no accumulator, and the stream ends after the last data word.

## Structure
- Package `inst_loader_pkg`:
  - State enum: IDLE, HDR, DATA, CSUM, FIN.
  - Constants `WORD_BYTES`=4 and `HDR_BYTES`=4.
- Sub-module `byte_assembler`: a 2-bit byte counter plus a 32-bit shift register. It emits a one-cycle `word_valid` with the completed little-endian word and is cleared on `start` or `reset`. It is reused for the header, the data words, and the checksum.

## Test plan
- Basic load: `start`, then stream 02 00 00 00, 78 56 34 12, EF BE AD DE → mem[0]=0x12345678, mem[1]=0xDEADBEEF. Exactly 2 `mem_we` pulses, `done` 2 cycles after the last byte, `word_count`=2, `error`=0.
- Backpressure: same stream with `in_valid` toggled randomly and `BASE_ADDR`=0x100 → writes to 0x100 and 0x101 with the same data, and no extra strobes.
- Empty load: header 00 00 00 00 → no `mem_we`, `done` pulses, `word_count`=0.
- Overflow: `ADDR_WIDTH`=4, N=17 → `error`=1 at `done`, zero writes. A following `start` clears `error`.
- Reset mid-word: assert `reset` after 2 data bytes → all outputs return to reset values. A fresh load then writes correctly from `BASE_ADDR`.
- Checksum (macro defined), N=1 word 0x00000005:
  - Checksum bytes 05 00 00 00 → `error`=0.
  - Checksum bytes 06 00 00 00 → `error`=1, and mem[0] is still written.

Source files
------------

// File: rtl/inst_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package inst_loader_pkg;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned HDR_BYTES  = 4;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    CSUM,
    FIN
  } state_e;

endpackage

// File: rtl/byte_assembler.sv
// Collects four stream bytes into a little-endian 32-bit word; word_valid_c_o
// is combinational so the word is available in the cycle its last byte lands.
module byte_assembler
  import inst_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              byte_valid_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic              word_valid_c_o,
  output logic [WORD_W-1:0] word_c_o
);

  localparam int unsigned SR_W = WORD_W - BYTE_W;

  logic [1:0]      cnt_q, cnt_d;
  logic [SR_W-1:0] sr_q, sr_d;

  // Next byte count / shift contents; new bytes enter at the top.
  always_comb begin
    cnt_d = cnt_q;
    sr_d  = sr_q;
    if (clear_i) begin
      cnt_d = '0;
      sr_d  = '0;
    end else if (byte_valid_i) begin
      cnt_d = cnt_q + 2'd1;
      sr_d  = {byte_i, sr_q[SR_W-1:BYTE_W]};
    end
  end

  assign word_valid_c_o = byte_valid_i && !clear_i && (cnt_q == 2'(WORD_BYTES - 1));
  assign word_c_o       = {byte_i, sr_q};

  // Byte counter and shift register state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      sr_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      sr_q  <= sr_d;
    end
  end

endmodule

// File: rtl/inst_loader.sv
// Program loader: parses a length header from a byte stream and writes the
// following little-endian words to instruction memory from BASE_ADDR upward.
// Optional trailing checksum word enabled by INST_LOADER_CHECKSUM_EN.
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 20,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [BYTE_W-1:0]     in_data,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_W-1:0]     mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   word_count
);

  localparam int unsigned CNT_W     = ADDR_WIDTH + 1;
  localparam logic [63:0] MAX_WORDS = (64'd1 << ADDR_WIDTH) - 64'(BASE_ADDR);
`ifdef INST_LOADER_CHECKSUM_EN
  localparam state_e      END_ST    = CSUM;
`else
  localparam state_e      END_ST    = FIN;
`endif

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      len_q, len_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]      wc_q, wc_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] maddr_q, maddr_d;
  logic [WORD_W-1:0]     wdata_q, wdata_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  rdy_q, rdy_d;
`ifdef INST_LOADER_CHECKSUM_EN
  logic [WORD_W-1:0]     sum_q, sum_d;
`endif

  logic              byte_fire;
  logic              asm_clear;
  logic              word_valid;
  logic [WORD_W-1:0] word;
  logic              last_word;

  assign byte_fire = in_valid && rdy_q;
  assign asm_clear = start && (state_q == IDLE);
  assign last_word = ((wc_q + CNT_W'(1)) == len_q);

  byte_assembler u_asm (
    .clk           (clk),
    .reset         (reset),
    .clear_i       (asm_clear),
    .byte_valid_i  (byte_fire),
    .byte_i        (in_data),
    .word_valid_c_o(word_valid),
    .word_c_o      (word)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    addr_d  = addr_q;
    wc_d    = wc_q;
    we_d    = 1'b0;
    maddr_d = maddr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    err_d   = err_q;
`ifdef INST_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = HDR;
          err_d   = 1'b0;
          wc_d    = '0;
          addr_d  = ADDR_WIDTH'(BASE_ADDR);
`ifdef INST_LOADER_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      HDR: begin
        if (word_valid) begin
          if (64'(word) > MAX_WORDS) begin
            err_d   = 1'b1;
            state_d = FIN;
          end else if (word == '0) begin
            state_d = END_ST;
          end else begin
            len_d   = CNT_W'(word);
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (word_valid) begin
          we_d    = 1'b1;
          maddr_d = addr_q;
          wdata_d = word;
          addr_d  = addr_q + ADDR_WIDTH'(1);
          wc_d    = wc_q + CNT_W'(1);
`ifdef INST_LOADER_CHECKSUM_EN
          sum_d   = sum_q + word;
`endif
          if (last_word) state_d = END_ST;
        end
      end
`ifdef INST_LOADER_CHECKSUM_EN
      CSUM: begin
        // Checksum verdict and done pulse leave together on the next cycle.
        if (word_valid) begin
          if (word != sum_q) err_d = 1'b1;
          done_d  = 1'b1;
          state_d = FIN;
        end
      end
`endif
      FIN: begin
        done_d  = !done_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    rdy_d  = (state_d == HDR) || (state_d == DATA) || (state_d == CSUM);
    busy_d = (state_d != IDLE) || done_d;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      len_q   <= '0;
      addr_q  <= '0;
      wc_q    <= '0;
      we_q    <= 1'b0;
      maddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      wc_q    <= wc_d;
      we_q    <= we_d;
      maddr_q <= maddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdy_q   <= rdy_d;
`ifdef INST_LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  assign in_ready   = rdy_q;
  assign mem_we     = we_q;
  assign mem_addr   = maddr_q;
  assign mem_wdata  = wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = err_q;
  assign word_count = wc_q;

endmodule

// File: tb/tb_inst_loader.sv
// Bench for inst_loader: two instances with different geometry, driven one at
// a time with random streams and checked against a list-based load model.
module tb_inst_loader;

  localparam int unsigned A_AW   = 20;
  localparam int unsigned A_BASE = 0;
  localparam int unsigned B_AW   = 9;
  localparam int unsigned B_BASE = 256;
`ifdef INST_LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic            a_start, a_valid, a_ready, a_we, a_busy, a_done, a_err;
  logic [7:0]      a_data;
  logic [A_AW-1:0] a_addr;
  logic [31:0]     a_wdata;
  logic [A_AW:0]   a_wc;
  logic            b_start, b_valid, b_ready, b_we, b_busy, b_done, b_err;
  logic [7:0]      b_data;
  logic [B_AW-1:0] b_addr;
  logic [31:0]     b_wdata;
  logic [B_AW:0]   b_wc;

  inst_loader #(.ADDR_WIDTH(A_AW), .BASE_ADDR(A_BASE)) u_dut_a (
    .clk(clk), .reset(reset), .start(a_start), .in_valid(a_valid), .in_data(a_data),
    .in_ready(a_ready), .mem_we(a_we), .mem_addr(a_addr), .mem_wdata(a_wdata),
    .busy(a_busy), .done(a_done), .error(a_err), .word_count(a_wc));

  inst_loader #(.ADDR_WIDTH(B_AW), .BASE_ADDR(B_BASE)) u_dut_b (
    .clk(clk), .reset(reset), .start(b_start), .in_valid(b_valid), .in_data(b_data),
    .in_ready(b_ready), .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_wdata),
    .busy(b_busy), .done(b_done), .error(b_err), .word_count(b_wc));

  int n_checks = 0;
  int n_pass   = 0;
  int sel      = 0;

  logic        o_ready, o_we, o_busy, o_done, o_err;
  logic [31:0] o_addr, o_wdata, o_wc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s (dut %0d): got 0x%0h expected 0x%0h", tag, sel, got, exp);
    else n_pass++;
  endtask

  task automatic sample();
    if (sel == 0) begin
      o_ready = a_ready; o_we = a_we; o_busy = a_busy; o_done = a_done; o_err = a_err;
      o_addr = 32'(a_addr); o_wdata = a_wdata; o_wc = 32'(a_wc);
    end else begin
      o_ready = b_ready; o_we = b_we; o_busy = b_busy; o_done = b_done; o_err = b_err;
      o_addr = 32'(b_addr); o_wdata = b_wdata; o_wc = 32'(b_wc);
    end
  endtask

  task automatic drive(input logic s, input logic v, input logic [7:0] d);
    a_start = (sel == 0) ? s : 1'b0;
    a_valid = (sel == 0) ? v : 1'b0;
    a_data  = (sel == 0) ? d : 8'h00;
    b_start = (sel == 1) ? s : 1'b0;
    b_valid = (sel == 1) ? v : 1'b0;
    b_data  = (sel == 1) ? d : 8'h00;
  endtask

  task automatic check_reset_outputs(input string tag);
    sample();
    check({tag, "_ready"}, 64'(o_ready), 64'd0);
    check({tag, "_we"},    64'(o_we),    64'd0);
    check({tag, "_addr"},  64'(o_addr),  64'd0);
    check({tag, "_wdata"}, 64'(o_wdata), 64'd0);
    check({tag, "_busy"},  64'(o_busy),  64'd0);
    check({tag, "_done"},  64'(o_done),  64'd0);
    check({tag, "_err"},   64'(o_err),   64'd0);
    check({tag, "_wc"},    64'(o_wc),    64'd0);
  endtask

  // One complete load: model = list of (base+i, word_i) writes, or none on overflow.
  task automatic run_load(input int dut, input logic [31:0] n, input int vpct,
                          input bit bad_csum, input bit poke, input bit fixed);
    logic [63:0] limit;
    logic [31:0] base, sum, w, wc_at_done;
    logic [7:0]  q[$];
    logic [31:0] ws[$];
    bit ovf, exp_err, pv, pr, v, err_at_done, busy_at_done;
    int last_acc, done_at, we_at, nwr, lat;
    sel = dut;
    base  = (dut == 0) ? 32'(A_BASE) : 32'(B_BASE);
    limit = (dut == 0) ? ((64'd1 << A_AW) - 64'(A_BASE)) : ((64'd1 << B_AW) - 64'(B_BASE));
    ovf   = (64'(n) > limit);
    for (int i = 0; i < 4; i++) q.push_back(n[8*i +: 8]);
    sum = 32'd0;
    if (!ovf) begin
      for (int i = 0; i < int'(n); i++) begin
        w = fixed ? ((i == 0) ? 32'h1234_5678 : 32'hDEAD_BEEF) : $urandom;
        ws.push_back(w);
        sum = sum + w;
        for (int b = 0; b < 4; b++) q.push_back(w[8*b +: 8]);
      end
    end
    if (CSUM_EN && !ovf) begin
      w = bad_csum ? sum + 32'd1 : sum;
      for (int b = 0; b < 4; b++) q.push_back(w[8*b +: 8]);
    end
    exp_err = ovf || (CSUM_EN && bad_csum);
    lat     = (CSUM_EN && !ovf) ? 1 : 2;
    last_acc = -1; done_at = -1; we_at = -1; nwr = 0; pv = 1'b0; pr = 1'b0;
    wc_at_done = '0; err_at_done = 1'b0; busy_at_done = 1'b0;

    drive(1'b1, 1'b0, 8'h00);
    @(negedge clk);
    for (int cyc = 0; cyc < 20000; cyc++) begin
      sample();
      if (cyc == 0) begin
        check("start_busy",  64'(o_busy),  64'd1);
        check("start_ready", 64'(o_ready), 64'd1);
        check("start_err",   64'(o_err),   64'd0);
        check("start_wc",    64'(o_wc),    64'd0);
      end
      if (pv && pr) begin
        void'(q.pop_front());
        last_acc = cyc - 1;
      end
      if (o_we) begin
        if (nwr < ws.size()) begin
          check("wr_addr", 64'(o_addr),  64'(base + 32'(nwr)));
          check("wr_data", 64'(o_wdata), 64'(ws[nwr]));
        end else begin
          check("extra_we", 64'(nwr + 1), 64'(ws.size()));
        end
        nwr++;
        we_at = cyc;
      end
      if (o_done) begin
        done_at = cyc; wc_at_done = o_wc; err_at_done = o_err; busy_at_done = o_busy;
        break;
      end
      v = (q.size() != 0) && (int'($urandom_range(0, 99)) < vpct);
      drive(poke && (cyc == 3), v, v ? q[0] : 8'h00);
      pv = v;
      pr = o_ready;
      @(negedge clk);
    end

    drive(1'b0, 1'b0, 8'h00);
    check("done_seen", 64'(done_at >= 0), 64'd1);
    if (done_at >= 0) begin
      check("done_latency", 64'(done_at - last_acc), 64'(lat));
      check("bytes_left",   64'(q.size()), 64'd0);
      check("num_writes",   64'(nwr), 64'(ws.size()));
      check("wc_at_done",   64'(wc_at_done), ovf ? 64'd0 : 64'(n));
      check("err_at_done",  64'(err_at_done), 64'(exp_err));
      check("busy_at_done", 64'(busy_at_done), 64'd1);
      if (!ovf && n != 0 && !CSUM_EN) check("we_to_done", 64'(done_at - we_at), 64'd1);
      @(negedge clk);
      sample();
      check("done_pulse", 64'(o_done),  64'd0);
      check("busy_after", 64'(o_busy),  64'd0);
      check("ready_idle", 64'(o_ready), 64'd0);
      check("err_sticky", 64'(o_err),   64'(exp_err));
      check("no_late_we", 64'(o_we),    64'd0);
    end
  endtask

  // Abort a load two bytes into its second group with an async reset.
  task automatic reset_mid_word(input int dut);
    logic [7:0] bytes [10];
    bytes = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB};
    sel = dut;
    drive(1'b1, 1'b0, 8'h00);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1, bytes[i]);
      @(negedge clk);
    end
    drive(1'b0, 1'b0, 8'h00);
    sample();
    check("pre_rst_wc",    64'(o_wc),    64'd1);
    check("pre_rst_wdata", 64'(o_wdata), 64'h4433_2211);
    reset = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_load(dut, 32'd2, 100, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    reset = 1'b1;
    sel = 0; drive(1'b0, 1'b0, 8'h00);
    sel = 1; drive(1'b0, 1'b0, 8'h00);
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin sel = s; check_reset_outputs("rst"); end
    reset = 1'b0;
    @(negedge clk);

    run_load(0, 32'd2, 100, 1'b0, 1'b0, 1'b1);            // basic
    run_load(1, 32'd2, 50,  1'b0, 1'b0, 1'b1);            // backpressure, base 0x100
    run_load(0, 32'd0, 100, 1'b0, 1'b0, 1'b0);            // empty
    run_load(1, 32'd257, 100, 1'b0, 1'b0, 1'b0);          // one past capacity
    run_load(1, 32'd1, 100, 1'b0, 1'b0, 1'b0);            // start clears error
    run_load(1, 32'd256, 100, 1'b0, 1'b0, 1'b0);          // exactly fills memory
    run_load(0, 32'h0010_0001, 100, 1'b0, 1'b0, 1'b0);
    run_load(0, 32'hFFFF_FFFF, 70, 1'b0, 1'b1, 1'b0);
    run_load(0, 32'd1, 100, 1'b1, 1'b0, 1'b0);            // corrupted checksum when enabled
    run_load(1, 32'd0, 100, 1'b1, 1'b0, 1'b0);
    reset_mid_word(0);
    reset_mid_word(1);
    for (int i = 0; i < 30; i++) begin
      run_load(int'($urandom_range(0, 1)), 32'($urandom_range(0, 6)),
               int'($urandom_range(30, 100)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
